neureka_accum_phase_sched: RTL and testbench
============================================

Name: neureka_accum_phase_sched

Overview:
Per-tile phase scheduler for the NEUREKA engine accumulator bank. For each output tile it sequences the phases streamin, accumulate, normquant, streamout and idle, issuing one-cycle goto pulses and serializer/deserializer clears. It computes the per-PE accumulator enable mask and the last-PE index. Progress comes from observed stream handshakes and step-completion pulses. It sits in the NEUREKA controller and drives the engine ctrl fields enable_accumulator, last_pe, clear_ser, clear_des and ctrl_accumulator.goto_*.

Parameters:
NR_PE, 9, number of PEs/accumulators (PE_H*PE_W)
NQ_LAT, 4, fixed normquant phase length in cycles (>=1)
CNT_W, 16, width of the accumulation-step and beat counters

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
enable_i  in  1  global enable; low freezes state, counters and pending pulses
clear_i  in  1  synchronous soft clear, same effect as rst_i
start_i  in  1  start one tile; sampled only in IDLE
streamin_en_i  in  1  tile runs the streamin phase
normquant_en_i  in  1  tile runs the normquant phase
nb_accum_i  in  CNT_W  accumulation steps per tile
nb_pe_i  in  $clog2(NR_PE+1)  active PEs
nb_beats_i  in  4  stream beats per PE (0 treated as 1)
accum_step_done_i  in  1  pulse: one accumulation step finished
streamin_beat_i  in  1  load_streamin valid&ready
streamout_beat_i  in  1  store_out valid&ready
goto_streamin_o / goto_accum_o / goto_normquant_o / goto_streamout_o / goto_idle_o  out  1 each  phase-entry pulses
clear_des_o  out  1  pulse: clear streamin deserializer
clear_ser_o  out  1  pulse: clear streamout serializer
enable_accumulator_o  out  NR_PE  bit i = 1 iff i < active PE count
last_pe_o  out  $clog2(NR_PE)  index of last active PE
busy_o  out  1  high in every state except IDLE
done_o  out  1  pulse: tile complete
state_o  out  3  IDLE=0, SIN=1, ACC=2, NQ=3, SOUT=4, FIN=5

Behaviour:
- Reset and clear (synchronous):
  - State goes to IDLE; all counters go to 0.
  - All outputs are 0: every pulse, enable_accumulator_o, last_pe_o, busy_o, state_o.
  - rst_i/clear_i take priority over start_i and enable_i, and abort a tile mid-operation with no done_o.
- Start:
  - Accepted when in IDLE with start_i=1 and enable_i=1; ignored while busy.
  - On acceptance, latch all configuration inputs; changes to them afterwards have no effect until the next start.
  - nb_pe_i=0 or nb_pe_i>NR_PE is treated as NR_PE. nb_beats_i=0 is treated as 1.
  - Load enable_accumulator_o and last_pe_o (active PEs - 1) at acceptance; they hold until return to IDLE, then clear to 0.
- First state after start (entered at t+1 for start at t):
  - SIN if streamin_en.
  - Otherwise ACC if nb_accum>0.
  - Otherwise NQ if normquant_en.
  - Otherwise SOUT.
- Phase entry pulses:
  - Each goto_*_o is registered and high exactly one cycle: the first cycle of the corresponding state.
  - clear_des_o pulses with goto_streamin_o; clear_ser_o pulses with goto_streamout_o.
- SIN:
  - Count streamin_beat_i up to TOT = active PEs * beats.
  - When the beat reaching TOT is seen, leave next cycle to ACC, or to NQ/SOUT if nb_accum=0 (same skip rules as start).
- ACC:
  - Count accum_step_done_i up to nb_accum.
  - On the pulse reaching nb_accum, leave to NQ if normquant_en, else to SOUT.
- NQ:
  - Stay exactly NQ_LAT cycles, then go to SOUT.
- SOUT:
  - Count streamout_beat_i up to TOT.
  - On the final beat, go to FIN.
- FIN:
  - Lasts one cycle with done_o=1 and goto_idle_o=1, then IDLE.
  - A start_i during FIN is ignored. Earliest back-to-back start is accepted in the first IDLE cycle.
- Out-of-phase events:
  - Events arriving outside their phase (e.g. streamout_beat_i in ACC) are ignored and never counted.
  - An event in the same cycle as the entry pulse is counted.
- Counters:
  - Zeroed on each phase entry.
  - Never wrap. Comparison is equality to the target; the target is reached before overflow by construction, since CNT_W holds NR_PE*15 and nb_accum.
- enable_i=0:
  - No state or counter changes; event inputs in that cycle are dropped.
  - A pulse due on entry is deferred to the next enabled cycle. Pulses are gated by enable_i, never duplicated.
  - Level outputs hold.

Test Plan:
1. Full tile: nb_pe=9, beats=2, nb_accum=3, both phase enables=1, NQ_LAT=4, events supplied back-to-back -> states SIN(18 beats), ACC(3), NQ(4 cycles), SOUT(18 beats), FIN. Expect one pulse each of goto_*, clear_des, clear_ser and done_o; mask=0x1FF; last_pe=8.
2. Partial PEs and skips: nb_pe=5, beats=1, streamin_en=0, normquant_en=0, nb_accum=0 -> start at t gives goto_streamout+clear_ser at t+1; mask=0x01F, last_pe=4; done_o one cycle after the 5th beat.
3. Config clamping: nb_pe=0 then nb_pe=12 -> mask=0x1FF, last_pe=8; nb_beats=0 -> SOUT ends after 9 beats.
4. Stall: enable_i low for 3 cycles mid-ACC with accum_step_done_i high -> no state or count change, steps not counted; resumes and completes after nb_accum counted pulses.
5. Abort and ignored events: rst_i during SOUT after 4 beats -> next cycle IDLE, all outputs 0, no done_o. streamout_beat_i during ACC -> not counted (SOUT still needs the full TOT).
6. Back-to-back: start_i held high through FIN -> second tile accepted in the first IDLE cycle; busy_o low exactly one cycle between tiles.

Source files
------------

// File: rtl/neureka_accum_phase_sched.sv
// Per-tile phase scheduler for the NEUREKA accumulator bank: sequences streamin,
// accumulate, normquant and streamout, and issues phase-entry and clear pulses.
module neureka_accum_phase_sched #(
   parameter int unsigned NR_PE  = 9,
   parameter int unsigned NQ_LAT = 4,
   parameter int unsigned CNT_W  = 16,
   localparam int unsigned PE_W  = $clog2(NR_PE + 1),
   localparam int unsigned LP_W  = (NR_PE > 1) ? $clog2(NR_PE) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic              clear_i,
   input  logic              start_i,
   input  logic              streamin_en_i,
   input  logic              normquant_en_i,
   input  logic [CNT_W-1:0]  nb_accum_i,
   input  logic [PE_W-1:0]   nb_pe_i,
   input  logic [3:0]        nb_beats_i,
   input  logic              accum_step_done_i,
   input  logic              streamin_beat_i,
   input  logic              streamout_beat_i,
   output logic              goto_streamin_o,
   output logic              goto_accum_o,
   output logic              goto_normquant_o,
   output logic              goto_streamout_o,
   output logic              goto_idle_o,
   output logic              clear_des_o,
   output logic              clear_ser_o,
   output logic [NR_PE-1:0]  enable_accumulator_o,
   output logic [LP_W-1:0]   last_pe_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [2:0]        state_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SIN  = 3'd1,
      S_ACC  = 3'd2,
      S_NQ   = 3'd3,
      S_SOUT = 3'd4,
      S_FIN  = 3'd5
   } state_t;

   localparam logic [PE_W-1:0]  PE_MAX  = PE_W'(NR_PE);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] NQ_LAST = CNT_W'(NQ_LAT - 1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   r_tot;
   logic [CNT_W-1:0]   r_nb_accum;
   logic               r_nq_en;
   logic [NR_PE-1:0]   r_mask;
   logic [LP_W-1:0]    r_last_pe;
   logic               r_go_sin, r_go_acc, r_go_nq, r_go_sout, r_go_idle;

   logic [PE_W-1:0]    w_pe_eff;
   logic [PE_W-1:0]    w_pe_m1;
   logic [3:0]         w_beats_eff;
   logic [NR_PE-1:0]   w_mask;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic               w_last_sin, w_last_acc, w_last_nq, w_last_sout;
   state_t             w_first, w_after_sin, w_after_acc;

   always_comb begin
      w_pe_eff    = (nb_pe_i == '0 || nb_pe_i > PE_MAX) ? PE_MAX : nb_pe_i;
      w_pe_m1     = w_pe_eff - PE_W'(1);
      w_beats_eff = (nb_beats_i == '0) ? 4'd1 : nb_beats_i;
      w_mask      = '0;
      for (int unsigned i = 0; i < NR_PE; i++) begin
         w_mask[i] = (PE_W'(i) < w_pe_eff);
      end
      w_cnt_inc   = r_cnt + CNT_ONE;
      w_last_sin  = (w_cnt_inc == r_tot);
      w_last_acc  = (w_cnt_inc == r_nb_accum);
      w_last_sout = (w_cnt_inc == r_tot);
      w_last_nq   = (r_cnt == NQ_LAST);
      w_after_acc = r_nq_en ? S_NQ : S_SOUT;
      w_after_sin = (r_nb_accum != '0) ? S_ACC : w_after_acc;
      w_first     = streamin_en_i ? S_SIN :
                    (nb_accum_i != '0) ? S_ACC :
                    normquant_en_i ? S_NQ : S_SOUT;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_tot      <= '0;
         r_nb_accum <= '0;
         r_nq_en    <= 1'b0;
         r_mask     <= '0;
         r_last_pe  <= '0;
         r_go_sin   <= 1'b0;
         r_go_acc   <= 1'b0;
         r_go_nq    <= 1'b0;
         r_go_sout  <= 1'b0;
         r_go_idle  <= 1'b0;
      end else if (enable_i) begin
         // Entry pulses stay pending through disabled cycles and retire on the first enabled one.
         r_go_sin  <= 1'b0;
         r_go_acc  <= 1'b0;
         r_go_nq   <= 1'b0;
         r_go_sout <= 1'b0;
         r_go_idle <= 1'b0;
         case (r_state)
            S_IDLE: if (start_i) begin
               r_state    <= w_first;
               r_cnt      <= '0;
               r_tot      <= CNT_W'(w_pe_eff) * CNT_W'(w_beats_eff);
               r_nb_accum <= nb_accum_i;
               r_nq_en    <= normquant_en_i;
               r_mask     <= w_mask;
               r_last_pe  <= w_pe_m1[LP_W-1:0];
               r_go_sin   <= (w_first == S_SIN);
               r_go_acc   <= (w_first == S_ACC);
               r_go_nq    <= (w_first == S_NQ);
               r_go_sout  <= (w_first == S_SOUT);
            end
            S_SIN: if (streamin_beat_i) begin
               if (w_last_sin) begin
                  r_state   <= w_after_sin;
                  r_cnt     <= '0;
                  r_go_acc  <= (w_after_sin == S_ACC);
                  r_go_nq   <= (w_after_sin == S_NQ);
                  r_go_sout <= (w_after_sin == S_SOUT);
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_ACC: if (accum_step_done_i) begin
               if (w_last_acc) begin
                  r_state   <= w_after_acc;
                  r_cnt     <= '0;
                  r_go_nq   <= (w_after_acc == S_NQ);
                  r_go_sout <= (w_after_acc == S_SOUT);
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_NQ: begin
               if (w_last_nq) begin
                  r_state   <= S_SOUT;
                  r_cnt     <= '0;
                  r_go_sout <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_SOUT: if (streamout_beat_i) begin
               if (w_last_sout) begin
                  r_state   <= S_FIN;
                  r_cnt     <= '0;
                  r_go_idle <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_FIN: begin
               r_state   <= S_IDLE;
               r_mask    <= '0;
               r_last_pe <= '0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign goto_streamin_o      = r_go_sin & enable_i;
   assign goto_accum_o         = r_go_acc & enable_i;
   assign goto_normquant_o     = r_go_nq & enable_i;
   assign goto_streamout_o     = r_go_sout & enable_i;
   assign goto_idle_o          = r_go_idle & enable_i;
   assign clear_des_o          = r_go_sin & enable_i;
   assign clear_ser_o          = r_go_sout & enable_i;
   assign done_o               = r_go_idle & enable_i;
   assign enable_accumulator_o = r_mask;
   assign last_pe_o            = r_last_pe;
   assign busy_o               = (r_state != S_IDLE);
   assign state_o              = r_state;

endmodule

// File: tb/tb_neureka_accum_phase_sched.sv
// Directed bench for neureka_accum_phase_sched: hand-computed phase timing,
// pulse counts, mask/last_pe, clamping, stalls, aborts and back-to-back tiles.
module tb_neureka_accum_phase_sched;

   localparam int unsigned NR_PE  = 9;
   localparam int unsigned NQ_LAT = 4;
   localparam int unsigned CNT_W  = 16;

   logic              clk_i = 1'b0;
   logic              rst_i, enable_i, clear_i, start_i;
   logic              streamin_en_i, normquant_en_i;
   logic [CNT_W-1:0]  nb_accum_i;
   logic [3:0]        nb_pe_i;
   logic [3:0]        nb_beats_i;
   logic              accum_step_done_i, streamin_beat_i, streamout_beat_i;
   logic              goto_streamin_o, goto_accum_o, goto_normquant_o, goto_streamout_o, goto_idle_o;
   logic              clear_des_o, clear_ser_o, busy_o, done_o;
   logic [NR_PE-1:0]  enable_accumulator_o;
   logic [3:0]        last_pe_o;
   logic [2:0]        state_o;

   always #5 clk_i = ~clk_i;

   neureka_accum_phase_sched #(
      .NR_PE  (NR_PE),
      .NQ_LAT (NQ_LAT),
      .CNT_W  (CNT_W)
   ) dut (
      .clk_i                (clk_i),
      .rst_i                (rst_i),
      .enable_i             (enable_i),
      .clear_i              (clear_i),
      .start_i              (start_i),
      .streamin_en_i        (streamin_en_i),
      .normquant_en_i       (normquant_en_i),
      .nb_accum_i           (nb_accum_i),
      .nb_pe_i              (nb_pe_i),
      .nb_beats_i           (nb_beats_i),
      .accum_step_done_i    (accum_step_done_i),
      .streamin_beat_i      (streamin_beat_i),
      .streamout_beat_i     (streamout_beat_i),
      .goto_streamin_o      (goto_streamin_o),
      .goto_accum_o         (goto_accum_o),
      .goto_normquant_o     (goto_normquant_o),
      .goto_streamout_o     (goto_streamout_o),
      .goto_idle_o          (goto_idle_o),
      .clear_des_o          (clear_des_o),
      .clear_ser_o          (clear_ser_o),
      .enable_accumulator_o (enable_accumulator_o),
      .last_pe_o            (last_pe_o),
      .busy_o               (busy_o),
      .done_o               (done_o),
      .state_o              (state_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Pulse counters sampled on the active edge (pre-update values).
   int n_gsin = 0, n_gacc = 0, n_gnq = 0, n_gsout = 0, n_gidle = 0;
   int n_cdes = 0, n_cser = 0, n_done = 0;
   int s_gsin, s_gacc, s_gnq, s_gsout, s_gidle, s_cdes, s_cser, s_done;

   always @(posedge clk_i) begin
      if (goto_streamin_o)  n_gsin  <= n_gsin + 1;
      if (goto_accum_o)     n_gacc  <= n_gacc + 1;
      if (goto_normquant_o) n_gnq   <= n_gnq + 1;
      if (goto_streamout_o) n_gsout <= n_gsout + 1;
      if (goto_idle_o)      n_gidle <= n_gidle + 1;
      if (clear_des_o)      n_cdes  <= n_cdes + 1;
      if (clear_ser_o)      n_cser  <= n_cser + 1;
      if (done_o)           n_done  <= n_done + 1;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic snap();
      s_gsin = n_gsin; s_gacc = n_gacc; s_gnq = n_gnq; s_gsout = n_gsout;
      s_gidle = n_gidle; s_cdes = n_cdes; s_cser = n_cser; s_done = n_done;
   endtask

   task automatic chk_pulses(input string tag, input int e_sin, input int e_acc,
                             input int e_nq, input int e_sout, input int e_idle);
      check({tag, " goto_sin cnt"},  n_gsin - s_gsin, e_sin);
      check({tag, " goto_acc cnt"},  n_gacc - s_gacc, e_acc);
      check({tag, " goto_nq cnt"},   n_gnq - s_gnq, e_nq);
      check({tag, " goto_sout cnt"}, n_gsout - s_gsout, e_sout);
      check({tag, " goto_idle cnt"}, n_gidle - s_gidle, e_idle);
      check({tag, " clear_des cnt"}, n_cdes - s_cdes, e_sin);
      check({tag, " clear_ser cnt"}, n_cser - s_cser, e_sout);
      check({tag, " done cnt"},      n_done - s_done, e_idle);
   endtask

   task automatic start_tile(input logic sin, input logic nq, input logic [15:0] nacc,
                             input logic [3:0] pe, input logic [3:0] beats);
      streamin_en_i  = sin;
      normquant_en_i = nq;
      nb_accum_i     = nacc;
      nb_pe_i        = pe;
      nb_beats_i     = beats;
      start_i        = 1'b1;
      step(1);
      start_i        = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; clear_i = 1'b0; enable_i = 1'b1; start_i = 1'b0;
      streamin_en_i = 1'b0; normquant_en_i = 1'b0; nb_accum_i = '0;
      nb_pe_i = '0; nb_beats_i = '0;
      accum_step_done_i = 1'b0; streamin_beat_i = 1'b0; streamout_beat_i = 1'b0;
      step(2);
      check("rst state", 32'(state_o), 0);
      check("rst busy", 32'(busy_o), 0);
      check("rst mask", 32'(enable_accumulator_o), 0);
      check("rst last_pe", 32'(last_pe_o), 0);
      check("rst goto_sout", 32'(goto_streamout_o), 0);
      rst_i = 1'b0;
      step(1);
      check("idle state", 32'(state_o), 0);

      // Test 1: full tile
      snap();
      start_tile(1'b1, 1'b1, 16'd3, 4'd9, 4'd2);
      check("t1 state sin", 32'(state_o), 1);
      check("t1 goto_sin", 32'(goto_streamin_o), 1);
      check("t1 clear_des", 32'(clear_des_o), 1);
      check("t1 mask", 32'(enable_accumulator_o), 'h1FF);
      check("t1 last_pe", 32'(last_pe_o), 8);
      check("t1 busy", 32'(busy_o), 1);
      streamin_beat_i = 1'b1;
      step(17);
      check("t1 sin hold", 32'(state_o), 1);
      step(1);
      streamin_beat_i = 1'b0;
      check("t1 state acc", 32'(state_o), 2);
      check("t1 goto_acc", 32'(goto_accum_o), 1);
      accum_step_done_i = 1'b1;
      step(2);
      check("t1 acc hold", 32'(state_o), 2);
      step(1);
      accum_step_done_i = 1'b0;
      check("t1 state nq", 32'(state_o), 3);
      check("t1 goto_nq", 32'(goto_normquant_o), 1);
      step(3);
      check("t1 nq hold", 32'(state_o), 3);
      step(1);
      check("t1 state sout", 32'(state_o), 4);
      check("t1 clear_ser", 32'(clear_ser_o), 1);
      streamout_beat_i = 1'b1;
      step(17);
      check("t1 sout hold", 32'(state_o), 4);
      step(1);
      streamout_beat_i = 1'b0;
      check("t1 state fin", 32'(state_o), 5);
      check("t1 done", 32'(done_o), 1);
      check("t1 goto_idle", 32'(goto_idle_o), 1);
      step(1);
      check("t1 back idle", 32'(state_o), 0);
      check("t1 idle busy", 32'(busy_o), 0);
      check("t1 idle mask", 32'(enable_accumulator_o), 0);
      check("t1 idle last_pe", 32'(last_pe_o), 0);
      chk_pulses("t1", 1, 1, 1, 1, 1);

      // Test 2: partial PEs, all optional phases skipped
      snap();
      start_tile(1'b0, 1'b0, 16'd0, 4'd5, 4'd1);
      check("t2 state sout", 32'(state_o), 4);
      check("t2 clear_ser", 32'(clear_ser_o), 1);
      check("t2 mask", 32'(enable_accumulator_o), 'h01F);
      check("t2 last_pe", 32'(last_pe_o), 4);
      nb_pe_i = 4'd2;
      streamout_beat_i = 1'b1;
      step(4);
      check("t2 sout hold", 32'(state_o), 4);
      check("t2 mask latched", 32'(enable_accumulator_o), 'h01F);
      step(1);
      streamout_beat_i = 1'b0;
      check("t2 done", 32'(done_o), 1);
      step(1);
      check("t2 back idle", 32'(state_o), 0);
      chk_pulses("t2", 0, 0, 0, 1, 1);

      // Test 3: clamping of nb_pe and nb_beats
      start_tile(1'b0, 1'b0, 16'd0, 4'd0, 4'd0);
      check("t3 pe0 mask", 32'(enable_accumulator_o), 'h1FF);
      check("t3 pe0 last_pe", 32'(last_pe_o), 8);
      streamout_beat_i = 1'b1;
      step(8);
      check("t3 beats0 hold", 32'(state_o), 4);
      step(1);
      streamout_beat_i = 1'b0;
      check("t3 beats0 fin", 32'(state_o), 5);
      step(1);
      start_tile(1'b0, 1'b0, 16'd0, 4'd12, 4'd3);
      check("t3 pe12 mask", 32'(enable_accumulator_o), 'h1FF);
      check("t3 pe12 last_pe", 32'(last_pe_o), 8);
      streamout_beat_i = 1'b1;
      step(26);
      check("t3 pe12 hold", 32'(state_o), 4);
      step(1);
      streamout_beat_i = 1'b0;
      check("t3 pe12 fin", 32'(state_o), 5);
      step(1);

      // Test 4: stall in ACC, then a deferred entry pulse
      snap();
      start_tile(1'b0, 1'b0, 16'd4, 4'd1, 4'd1);
      check("t4 state acc", 32'(state_o), 2);
      accum_step_done_i = 1'b1;
      step(1);
      enable_i = 1'b0;
      step(3);
      check("t4 stalled acc", 32'(state_o), 2);
      enable_i = 1'b1;
      step(2);
      check("t4 stall not counted", 32'(state_o), 2);
      step(1);
      accum_step_done_i = 1'b0;
      check("t4 state sout", 32'(state_o), 4);
      enable_i = 1'b0;
      #1;
      check("t4 pulse gated", 32'(goto_streamout_o), 0);
      step(2);
      check("t4 stalled sout", 32'(state_o), 4);
      check("t4 pulse still gated", 32'(clear_ser_o), 0);
      enable_i = 1'b1;
      #1;
      check("t4 pulse deferred", 32'(goto_streamout_o), 1);
      streamout_beat_i = 1'b1;
      step(1);
      streamout_beat_i = 1'b0;
      check("t4 state fin", 32'(state_o), 5);
      step(1);
      check("t4 back idle", 32'(state_o), 0);
      chk_pulses("t4", 0, 1, 0, 1, 1);

      // Test 5a: streamout beats during ACC are ignored
      start_tile(1'b0, 1'b0, 16'd2, 4'd3, 4'd1);
      streamout_beat_i = 1'b1;
      step(1);
      streamout_beat_i = 1'b0;
      accum_step_done_i = 1'b1;
      step(1);
      check("t5 acc hold", 32'(state_o), 2);
      step(1);
      accum_step_done_i = 1'b0;
      check("t5 state sout", 32'(state_o), 4);
      streamout_beat_i = 1'b1;
      step(2);
      check("t5 oop beat ignored", 32'(state_o), 4);
      step(1);
      streamout_beat_i = 1'b0;
      check("t5 state fin", 32'(state_o), 5);
      step(1);

      // Test 5b: reset and soft clear abort a tile
      snap();
      start_tile(1'b0, 1'b0, 16'd0, 4'd9, 4'd1);
      streamout_beat_i = 1'b1;
      step(4);
      streamout_beat_i = 1'b0;
      rst_i = 1'b1;
      step(1);
      rst_i = 1'b0;
      check("t5 abort state", 32'(state_o), 0);
      check("t5 abort busy", 32'(busy_o), 0);
      check("t5 abort mask", 32'(enable_accumulator_o), 0);
      check("t5 abort last_pe", 32'(last_pe_o), 0);
      check("t5 abort done", 32'(done_o), 0);
      step(2);
      chk_pulses("t5", 0, 0, 0, 1, 0);
      start_tile(1'b1, 1'b0, 16'd0, 4'd2, 4'd1);
      check("t5 clr pre sin", 32'(state_o), 1);
      clear_i = 1'b1;
      step(1);
      clear_i = 1'b0;
      check("t5 clear state", 32'(state_o), 0);
      check("t5 clear mask", 32'(enable_accumulator_o), 0);

      // Test 6: back-to-back with start held high through FIN
      snap();
      streamin_en_i = 1'b0; normquant_en_i = 1'b0; nb_accum_i = '0;
      nb_pe_i = 4'd1; nb_beats_i = 4'd1;
      start_i = 1'b1;
      step(1);
      check("t6 first sout", 32'(state_o), 4);
      streamout_beat_i = 1'b1;
      step(1);
      streamout_beat_i = 1'b0;
      check("t6 fin ignores start", 32'(state_o), 5);
      step(1);
      check("t6 idle gap state", 32'(state_o), 0);
      check("t6 idle gap busy", 32'(busy_o), 0);
      step(1);
      check("t6 second accepted", 32'(state_o), 4);
      check("t6 second busy", 32'(busy_o), 1);
      check("t6 second goto", 32'(goto_streamout_o), 1);
      start_i = 1'b0;
      streamout_beat_i = 1'b1;
      step(1);
      streamout_beat_i = 1'b0;
      check("t6 second fin", 32'(state_o), 5);
      step(1);
      check("t6 end idle", 32'(state_o), 0);
      chk_pulses("t6", 0, 0, 0, 2, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
